// File: rtl/inverse_lifting_recon_if.sv
// Coefficient-pair input stream and reconstructed-sample output stream
// for the inverse 5/3 lifting stage.
interface inverse_lifting_recon_if #(
    parameter int W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_s;
    logic [W-1:0] in_d;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_first;
    logic         out_last;

    modport slave (
        input  in_valid, in_s, in_d, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last
    );

    modport master (
        output in_valid, in_s, in_d, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/inverse_lifting_recon.sv
// Inverse LeGall 5/3 integer lifting: rebuilds x[2n], x[2n+1] from (s[n], d[n])
// pairs with symmetric extension at both frame edges.
module inverse_lifting_recon #(
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    inverse_lifting_recon_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, HOLD, EMIT_E, EMIT_O} state_t;

    localparam logic signed [W+1:0] ROUND_TWO = (W+2)'(2);

    state_t       state_reg, state_next;
    logic [W-1:0] e_pend_reg, e_pend_next;
    logic [W-1:0] d_pend_reg, d_pend_next;
    logic [W-1:0] e_new_reg, e_new_next;
    logic [W-1:0] d_new_reg, d_new_next;
    logic [W-1:0] o_pend_reg, o_pend_next;
    logic         first_f_reg, first_f_next;
    logic         final_f_reg, final_f_next;
    logic         last_new_reg, last_new_next;

    logic                accept, emit;
    logic signed [W+1:0] d_prev_x, even_sum, e_full, odd_sum, o_full;
    logic [W-1:0]        e_in, o_in;
    logic                unused_first;

    function automatic logic signed [W+1:0] sx(input logic [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Frame start is implied by accepting in EMPTY, so the marker carries no extra information.
    assign unused_first = bus.in_first;

    assign bus.in_ready = !rst && ((state_reg == EMPTY) || (state_reg == HOLD));
    assign accept       = bus.in_valid && bus.in_ready;
    assign emit         = bus.out_valid && bus.out_ready;

    // Pair 0 mirrors d[-1] = d[0]; afterwards d[n-1] comes from the pending pair.
    assign d_prev_x = (state_reg == EMPTY) ? sx(bus.in_d) : sx(d_pend_reg);
    assign even_sum = d_prev_x + sx(bus.in_d) + ROUND_TWO;
    assign e_full   = sx(bus.in_s) - (even_sum >>> 2);
    assign e_in     = e_full[W-1:0];
    assign odd_sum  = sx(e_pend_reg) + sx(e_in);
    assign o_full   = sx(d_pend_reg) + (odd_sum >>> 1);
    assign o_in     = o_full[W-1:0];

    always_comb begin
        state_next    = state_reg;
        e_pend_next   = e_pend_reg;
        d_pend_next   = d_pend_reg;
        e_new_next    = e_new_reg;
        d_new_next    = d_new_reg;
        o_pend_next   = o_pend_reg;
        first_f_next  = first_f_reg;
        final_f_next  = final_f_reg;
        last_new_next = last_new_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    e_pend_next   = e_in;
                    d_pend_next   = bus.in_d;
                    first_f_next  = 1'b1;
                    last_new_next = 1'b0;
                    if (bus.in_last) begin
                        // Right-edge mirror e[N] = e[N-1] collapses the odd step to d + e.
                        o_pend_next  = bus.in_d + e_in;
                        final_f_next = 1'b1;
                        state_next   = EMIT_E;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    e_new_next    = e_in;
                    d_new_next    = bus.in_d;
                    o_pend_next   = o_in;
                    last_new_next = bus.in_last;
                    state_next    = EMIT_E;
                end
            end
            EMIT_E: begin
                if (emit) begin
                    first_f_next = 1'b0;
                    state_next   = EMIT_O;
                end
            end
            EMIT_O: begin
                if (emit) begin
                    if (final_f_reg) begin
                        final_f_next = 1'b0;
                        state_next   = EMPTY;
                    end else begin
                        e_pend_next = e_new_reg;
                        d_pend_next = d_new_reg;
                        if (last_new_reg) begin
                            o_pend_next  = d_new_reg + e_new_reg;
                            final_f_next = 1'b1;
                            state_next   = EMIT_E;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            e_pend_reg   <= '0;
            d_pend_reg   <= '0;
            e_new_reg    <= '0;
            d_new_reg    <= '0;
            o_pend_reg   <= '0;
            first_f_reg  <= 1'b0;
            final_f_reg  <= 1'b0;
            last_new_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            e_pend_reg   <= e_pend_next;
            d_pend_reg   <= d_pend_next;
            e_new_reg    <= e_new_next;
            d_new_reg    <= d_new_next;
            o_pend_reg   <= o_pend_next;
            first_f_reg  <= first_f_next;
            final_f_reg  <= final_f_next;
            last_new_reg <= last_new_next;
        end
    end

    // Outputs are a pure mux of state and registers, so they cannot move under backpressure.
    assign bus.out_valid = (state_reg == EMIT_E) || (state_reg == EMIT_O);
    assign bus.out_data  = (state_reg == EMIT_E) ? e_pend_reg :
                           (state_reg == EMIT_O) ? o_pend_reg : '0;
    assign bus.out_first = (state_reg == EMIT_E) && first_f_reg;
    assign bus.out_last  = (state_reg == EMIT_O) && final_f_reg;
endmodule

// File: tb/tb_inverse_lifting_recon.sv
// Directed and forward-model-driven checks of the inverse 5/3 lifting stage.
module tb_inverse_lifting_recon;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] tb_s  [0:63];
    logic [31:0] tb_d  [0:63];
    logic [31:0] exp_x [0:127];

    inverse_lifting_recon_if #(.W(32)) bus ();

    inverse_lifting_recon #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_frame_a();
        tb_s[0] = 32'd10; tb_d[0] = 32'd0;
        tb_s[1] = 32'd33; tb_d[1] = 32'd10;
        exp_x[0] = 32'd10; exp_x[1] = 32'd20; exp_x[2] = 32'd30; exp_x[3] = 32'd40;
    endtask

    // Forward 5/3 transform of random samples; the inverse must give them back exactly.
    task automatic load_random(input int np);
        int xv [0:127];
        int dv [0:63];
        int xr, dm;
        for (int i = 0; i < 2*np; i++) xv[i] = int'($urandom_range(60000)) - 30000;
        for (int n = 0; n < np; n++) begin
            xr = (n == np-1) ? xv[2*n] : xv[2*n+2];
            dv[n] = xv[2*n+1] - ((xv[2*n] + xr) >>> 1);
        end
        for (int n = 0; n < np; n++) begin
            dm = (n == 0) ? dv[0] : dv[n-1];
            tb_s[n] = xv[2*n] + ((dm + dv[n] + 2) >>> 2);
            tb_d[n] = dv[n];
        end
        for (int i = 0; i < 2*np; i++) exp_x[i] = xv[i];
    endtask

    task automatic run_frame(input int np, input int vpct, input int rpct,
                             input int stall, input bit chk_lat, input string tag);
        int sent, got, cyc, stall_left, lat_ref, first_out, nfirst, nlast;
        bit acc;
        sent = 0; got = 0; cyc = 0; stall_left = stall;
        lat_ref = -1; first_out = -1; nfirst = 0; nlast = 0; acc = 1'b1;
        bus.in_valid = 1'b0;
        while ((got < 2*np) && (cyc < 4000)) begin
            @(negedge clk);
            cyc++;
            if (sent < np) begin
                if (acc || !bus.in_valid) bus.in_valid = ($urandom_range(99) < vpct);
                bus.in_s     = tb_s[sent];
                bus.in_d     = tb_d[sent];
                bus.in_first = (sent == 0);
                bus.in_last  = (sent == np-1);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid && stall_left > 0) bus.out_ready = 1'b0;
            else bus.out_ready = ($urandom_range(99) < rpct);
            #1;
            if (bus.out_valid && !bus.out_ready && stall_left > 0) begin
                stall_left--;
                check({tag, "_stall_data"}, bus.out_data, exp_x[got]);
                check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                if (sent == ((np > 1) ? 1 : 0)) lat_ref = cyc;
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (first_out < 0) first_out = cyc;
                check({tag, "_data"}, bus.out_data, exp_x[got]);
                check({tag, "_first"}, 32'(bus.out_first), 32'(got == 0));
                check({tag, "_last"}, 32'(bus.out_last), 32'(got == 2*np-1));
                nfirst += int'(bus.out_first);
                nlast  += int'(bus.out_last);
                got++;
            end
        end
        bus.in_valid = 1'b0;
        check({tag, "_sample_count"}, 32'(got), 32'(2*np));
        check({tag, "_first_count"}, 32'(nfirst), 32'd1);
        check({tag, "_last_count"}, 32'(nlast), 32'd1);
        if (chk_lat) check({tag, "_latency"}, 32'(first_out), 32'(lat_ref + 1));
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_s = '0; bus.in_d = '0;
        bus.in_first = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_first", 32'(bus.out_first), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        load_frame_a();
        run_frame(2, 100, 100, 0, 1'b1, "frame_a");
        check_idle("frame_a");

        tb_s[0] = 32'd7; tb_d[0] = -32'sd3;
        exp_x[0] = 32'd8; exp_x[1] = 32'd5;
        run_frame(1, 100, 100, 0, 1'b1, "single_neg");
        check_idle("single_neg");

        tb_s[0] = 32'h7FFF_FFFF; tb_d[0] = -32'sd8;
        exp_x[0] = 32'h8000_0003; exp_x[1] = 32'h7FFF_FFFB;
        run_frame(1, 100, 100, 0, 1'b0, "wrap");

        load_frame_a();
        run_frame(2, 100, 100, 5, 1'b0, "backpressure");
        check_idle("backpressure");

        // Abort a 3-pair frame once while holding pair 0 and once while emitting.
        for (int k = 1; k <= 2; k++) begin
            for (int p = 0; p < k; p++) begin
                @(negedge clk);
                bus.in_valid = 1'b1; bus.in_s = 32'd100 + 32'(p); bus.in_d = 32'd4;
                bus.in_first = (p == 0); bus.in_last = 1'b0; bus.out_ready = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b0; rst = 1'b1;
            #1;
            check("abort_rst_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("abort_out_valid", 32'(bus.out_valid), 32'd0);
            check("abort_out_data", bus.out_data, 32'd0);
            check("abort_out_first", 32'(bus.out_first), 32'd0);
            check("abort_out_last", 32'(bus.out_last), 32'd0);
            check("abort_in_ready", 32'(bus.in_ready), 32'd1);
            load_frame_a();
            run_frame(2, 100, 100, 0, 1'b1, "after_abort");
        end

        for (int f = 0; f < 2; f++) begin
            load_random(64);
            run_frame(64, 60, 55, 0, 1'b0, "random");
        end
        check_idle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
